// File: rtl/counter_date_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_date_pkg
// Description : Shared constants and BCD helpers for the counter_date stage.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_date_pkg;

    localparam logic [7:0] c_len_28    = 8'h28;
    localparam logic [7:0] c_len_29    = 8'h29;
    localparam logic [7:0] c_len_30    = 8'h30;
    localparam logic [7:0] c_len_31    = 8'h31;

    localparam logic [7:0] c_day_rst   = 8'h01;
    localparam logic [7:0] c_month_rst = 8'h01;
    localparam logic [7:0] c_year_rst  = 8'h00;

    localparam logic [6:0] c_seg_off   = 7'h7F;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD +1; caller handles the wrap at the top of the range.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {4'(v[7:4] + 4'd1), 4'd0};
        else
            return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    // year mod 4 == 0 evaluated directly on the two BCD digits
    function automatic logic is_leap_bcd(input logic [7:0] y);
        if (!y[4])
            return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        else
            return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    endfunction

endpackage : counter_date_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : BCD digit to active-low 7-segment {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import counter_date_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_seg_off;
        case (i_bcd)
            4'd0:    o_seg = 7'h40;
            4'd1:    o_seg = 7'h79;
            4'd2:    o_seg = 7'h24;
            4'd3:    o_seg = 7'h30;
            4'd4:    o_seg = 7'h19;
            4'd5:    o_seg = 7'h12;
            4'd6:    o_seg = 7'h02;
            4'd7:    o_seg = 7'h78;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h10;
            default: o_seg = c_seg_off;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/date_month_len.sv
`default_nettype none
// ============================================================================
// Module      : date_month_len
// Description : Month length in BCD for a BCD month/year. February honours
//               leap years only when LEAP_YEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module date_month_len
    import counter_date_pkg::*;
(
    input  logic [7:0] i_month_bcd,
    input  logic [7:0] i_year_bcd,
    output logic [7:0] o_len_bcd
);

`ifdef LEAP_YEAR_EN
    localparam logic c_leap_en = 1'b1;
`else
    localparam logic c_leap_en = 1'b0;
`endif

    logic w_feb_29;

    assign w_feb_29 = c_leap_en && is_leap_bcd(i_year_bcd);

    // Out-of-range months fall to 31; load validation rejects them separately.
    always_comb begin
        o_len_bcd = c_len_31;
        case (i_month_bcd)
            8'h02:                      o_len_bcd = w_feb_29 ? c_len_29 : c_len_28;
            8'h04, 8'h06, 8'h09, 8'h11: o_len_bcd = c_len_30;
            default:                    o_len_bcd = c_len_31;
        endcase
    end

endmodule : date_month_len
`default_nettype wire

// File: rtl/counter_date.sv
`default_nettype none
// ============================================================================
// Module      : counter_date
// Description : BCD day/month/year calendar stage (2000-2099) with validated
//               load, 7-segment outputs and century carry. Leap-year February
//               is enabled by defining LEAP_YEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_date
    import counter_date_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ch_day,
    input  logic       set_en,
    input  logic [7:0] set_day,
    input  logic [7:0] set_month,
    input  logic [7:0] set_year,
    output logic [7:0] day_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic [6:0] seg_day_unit,
    output logic [6:0] seg_day_ten,
    output logic [6:0] seg_mon_unit,
    output logic [6:0] seg_mon_ten,
    output logic [6:0] seg_yr_unit,
    output logic [6:0] seg_yr_ten,
    output logic       set_err,
    output logic       cy_century
);

    logic [7:0] r_day;
    logic [7:0] r_month;
    logic [7:0] r_year;
    logic       r_set_err;

    logic [7:0] w_cur_len;
    logic [7:0] w_set_len;
    logic [7:0] w_day_nxt;
    logic [7:0] w_month_nxt;
    logic [7:0] w_year_nxt;
    logic       w_day_last;
    logic       w_set_valid;
    logic       w_load_ok;
    logic       w_load_bad;

    date_month_len u_len_cur (
        .i_month_bcd (r_month),
        .i_year_bcd  (r_year),
        .o_len_bcd   (w_cur_len)
    );

    date_month_len u_len_set (
        .i_month_bcd (set_month),
        .i_year_bcd  (set_year),
        .o_len_bcd   (w_set_len)
    );

    // Digit-valid BCD compares the same as its binary encoding.
    assign w_set_valid = bcd_ok(set_day) && bcd_ok(set_month) && bcd_ok(set_year)
                      && (set_month >= 8'h01) && (set_month <= 8'h12)
                      && (set_day   >= 8'h01) && (set_day   <= w_set_len);

    assign w_load_ok  = set_en &&  w_set_valid;
    assign w_load_bad = set_en && !w_set_valid;
    assign w_day_last = (r_day >= w_cur_len);

    assign cy_century = ch_day && (r_day == w_cur_len)
                     && (r_month == 8'h12) && (r_year == 8'h99);

    always_comb begin
        w_day_nxt   = r_day;
        w_month_nxt = r_month;
        w_year_nxt  = r_year;
        if (w_load_ok) begin
            w_day_nxt   = set_day;
            w_month_nxt = set_month;
            w_year_nxt  = set_year;
        end else if (ch_day) begin
            if (!w_day_last) begin
                w_day_nxt = bcd_inc(r_day);
            end else begin
                w_day_nxt = c_day_rst;
                if (r_month == 8'h12) begin
                    w_month_nxt = c_month_rst;
                    w_year_nxt  = (r_year == 8'h99) ? c_year_rst : bcd_inc(r_year);
                end else begin
                    w_month_nxt = bcd_inc(r_month);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_day     <= c_day_rst;
            r_month   <= c_month_rst;
            r_year    <= c_year_rst;
            r_set_err <= 1'b0;
        end else begin
            r_day     <= w_day_nxt;
            r_month   <= w_month_nxt;
            r_year    <= w_year_nxt;
            r_set_err <= w_load_bad;
        end
    end

    assign day_bcd   = r_day;
    assign month_bcd = r_month;
    assign year_bcd  = r_year;
    assign set_err   = r_set_err;

    bcd_to_7seg u_seg_day_unit (.i_bcd(r_day[3:0]),   .o_seg(seg_day_unit));
    bcd_to_7seg u_seg_day_ten  (.i_bcd(r_day[7:4]),   .o_seg(seg_day_ten));
    bcd_to_7seg u_seg_mon_unit (.i_bcd(r_month[3:0]), .o_seg(seg_mon_unit));
    bcd_to_7seg u_seg_mon_ten  (.i_bcd(r_month[7:4]), .o_seg(seg_mon_ten));
    bcd_to_7seg u_seg_yr_unit  (.i_bcd(r_year[3:0]),  .o_seg(seg_yr_unit));
    bcd_to_7seg u_seg_yr_ten   (.i_bcd(r_year[7:4]),  .o_seg(seg_yr_ten));

endmodule : counter_date
`default_nettype wire

// File: tb/tb_counter_date.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_date
// Description : Self-checking bench for counter_date against an integer
//               calendar model; honours LEAP_YEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_date;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ch_day = 1'b0;
    logic       set_en = 1'b0;
    logic [7:0] set_day = 8'h00;
    logic [7:0] set_month = 8'h00;
    logic [7:0] set_year = 8'h00;
    logic [7:0] day_bcd, month_bcd, year_bcd;
    logic [6:0] seg_day_unit, seg_day_ten, seg_mon_unit, seg_mon_ten;
    logic [6:0] seg_yr_unit, seg_yr_ten;
    logic       set_err, cy_century;

    int n_pass  = 0;
    int n_total = 0;

    // Reference date as plain integers
    int md = 1, mm = 1, my = 0;
    bit me = 1'b0;

    always #5 clk = ~clk;

    counter_date dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ch_day       (ch_day),
        .set_en       (set_en),
        .set_day      (set_day),
        .set_month    (set_month),
        .set_year     (set_year),
        .day_bcd      (day_bcd),
        .month_bcd    (month_bcd),
        .year_bcd     (year_bcd),
        .seg_day_unit (seg_day_unit),
        .seg_day_ten  (seg_day_ten),
        .seg_mon_unit (seg_mon_unit),
        .seg_mon_ten  (seg_mon_ten),
        .seg_yr_unit  (seg_yr_unit),
        .seg_yr_ten   (seg_yr_ten),
        .set_err      (set_err),
        .cy_century   (cy_century)
    );

    function automatic int mlen(input int m, input int y);
        bit leap;
`ifdef LEAP_YEAR_EN
        leap = (y % 4 == 0);
`else
        leap = 1'b0;
`endif
        if (m == 2) return leap ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] segd(input int dgt);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[dgt];
    endfunction

    function automatic bit load_valid(input logic [7:0] sd, input logic [7:0] sm,
                                      input logic [7:0] sy);
        int d, m, y;
        if (sd[7:4] > 9 || sd[3:0] > 9 || sm[7:4] > 9 || sm[3:0] > 9 ||
            sy[7:4] > 9 || sy[3:0] > 9)
            return 1'b0;
        d = int'(sd[7:4]) * 10 + int'(sd[3:0]);
        m = int'(sm[7:4]) * 10 + int'(sm[3:0]);
        y = int'(sy[7:4]) * 10 + int'(sy[3:0]);
        return (m >= 1) && (m <= 12) && (d >= 1) && (d <= mlen(m, y));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h (date %0d/%0d/%0d)",
                    tag, obs, exp, md, mm, my);
    endtask

    task automatic check_state();
        chk("day_bcd",   64'(day_bcd),   64'(tobcd(md)));
        chk("month_bcd", 64'(month_bcd), 64'(tobcd(mm)));
        chk("year_bcd",  64'(year_bcd),  64'(tobcd(my)));
        chk("set_err",   64'(set_err),   64'(me));
        chk("segments",
            64'({seg_day_ten, seg_day_unit, seg_mon_ten, seg_mon_unit, seg_yr_ten, seg_yr_unit}),
            64'({segd(md / 10), segd(md % 10), segd(mm / 10), segd(mm % 10),
                 segd(my / 10), segd(my % 10)}));
    endtask

    // One clock: drive at negedge, check carry before the edge, state after.
    task automatic step(input bit ch, input bit se, input logic [7:0] sd,
                        input logic [7:0] sm, input logic [7:0] sy);
        bit exp_cy;
        @(negedge clk);
        ch_day = ch; set_en = se; set_day = sd; set_month = sm; set_year = sy;
        #1;
        exp_cy = ch && (md == mlen(mm, my)) && (mm == 12) && (my == 99);
        chk("cy_century", 64'(cy_century), 64'(exp_cy));
        @(posedge clk);
        if (se && load_valid(sd, sm, sy)) begin
            md = int'(sd[7:4]) * 10 + int'(sd[3:0]);
            mm = int'(sm[7:4]) * 10 + int'(sm[3:0]);
            my = int'(sy[7:4]) * 10 + int'(sy[3:0]);
            me = 1'b0;
        end else begin
            me = se;
            if (ch) begin
                if (md < mlen(mm, my)) md++;
                else begin
                    md = 1;
                    if (mm < 12) mm++;
                    else begin
                        mm = 1;
                        my = (my + 1) % 100;
                    end
                end
            end
        end
        #1;
        check_state();
    endtask

    task automatic load(input logic [7:0] sd, input logic [7:0] sm, input logic [7:0] sy);
        step(1'b0, 1'b1, sd, sm, sy);
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Reset applied between clock edges, checked before any edge arrives.
    task automatic do_reset();
        @(posedge clk);
        #3;
        ch_day = 1'b0; set_en = 1'b0;
        reset_n = 1'b0;
        #1;
        md = 1; mm = 1; my = 0; me = 1'b0;
        check_state();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rd, rm, ry;
        int r;

        do_reset();
        for (int i = 0; i < 31; i++) tick();

        load(8'h28, 8'h02, 8'h23); tick();
        load(8'h28, 8'h02, 8'h24); tick();
        load(8'h29, 8'h02, 8'h24); tick();

        load(8'h30, 8'h04, 8'h10); tick();
        load(8'h31, 8'h04, 8'h10);
        idle();

        // Rejected load alongside a day pulse: the pulse still counts
        step(1'b1, 1'b1, 8'h00, 8'h05, 8'h10);

        load(8'h31, 8'h12, 8'h99); tick();
        idle();

        load(8'h06, 8'h07, 8'h07);
        step(1'b1, 1'b1, 8'h07, 8'h07, 8'h07);

        load(8'h15, 8'h06, 8'h45);
        do_reset();
        tick();

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                rd = 8'($urandom); rm = 8'($urandom); ry = 8'($urandom);
                step(1'($urandom), 1'b1, rd, rm, ry);
            end else if (r <= 2) begin
                rd = tobcd(int'($urandom_range(1, 31)));
                rm = tobcd(int'($urandom_range(1, 12)));
                ry = tobcd(int'($urandom_range(0, 99)));
                step(1'($urandom), 1'b1, rd, rm, ry);
            end else if (r == 3) begin
                rd = tobcd(int'($urandom_range(29, 31)));
                step(1'b1, 1'b1, rd, 8'h12, 8'h99);
            end else begin
                step(r > 5, 1'b0, 8'h00, 8'h00, 8'h00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_counter_date
`default_nettype wire
